// File: rtl/virtual_inj_pkg.sv
// rtl/virtual_inj_pkg.sv - flit encoding and FSM states shared by the cast injector and sink checker
package virtual_inj_pkg;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b00;
  localparam logic [1:0] TAIL = 2'b10;

  localparam int SID_LSB = 0;
  localparam int SID_W   = 10;
  localparam int SEQ_LSB = 10;
  localparam int SEQ_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
    ST_TAIL,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [1:0]       ftype;
    logic [SEQ_W-1:0] seq;
    logic [SID_W-1:0] sid;
  } hdr_t;

  function automatic hdr_t make_head(input logic [SID_W-1:0] sid, input logic [SEQ_W-1:0] seq);
    hdr_t h;
    h.ftype = HEAD;
    h.seq   = seq;
    h.sid   = sid;
    return h;
  endfunction

  function automatic hdr_t make_tail(input logic [SID_W-1:0] sid, input logic [SEQ_W-1:0] seq);
    hdr_t h;
    h.ftype = TAIL;
    h.seq   = seq;
    h.sid   = sid;
    return h;
  endfunction

endpackage

// File: rtl/virtual_cast_injector.sv
// rtl/virtual_cast_injector.sv - framed head/body/tail flit source for the cast network
// Optional stall counter output enabled by VIRTUAL_INJ_STALL_CNT_EN.
module virtual_cast_injector
  import virtual_inj_pkg::*;
#(
  parameter int unsigned DW         = 64,
  parameter logic [9:0]  STREAM_ID  = 10'd0,
  parameter int unsigned PKT_LEN    = 4,
  parameter int unsigned NUM_PKTS   = 8,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i,
  output logic          busy_o,
  output logic          done_o
`ifdef VIRTUAL_INJ_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt_o
`endif
);

  state_t        r_state;
  logic [31:0]   r_pkt_cnt;
  logic [DW-3:0] r_payload;
  logic [31:0]   r_body_cnt;
  logic [31:0]   r_gap_cnt;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_busy;
  logic          r_done;

  state_t        w_state;
  logic [31:0]   w_pkt_cnt;
  logic [DW-3:0] w_payload;
  logic [31:0]   w_body_cnt;
  logic [31:0]   w_gap_cnt;
  logic          w_xfer;
  hdr_t          w_hdr;
  logic [DW-1:0] w_data;

  assign w_xfer = r_valid & ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pkt_cnt  <= '0;
      r_payload  <= '0;
      r_body_cnt <= '0;
      r_gap_cnt  <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pkt_cnt  <= w_pkt_cnt;
      r_payload  <= w_payload;
      r_body_cnt <= w_body_cnt;
      r_gap_cnt  <= w_gap_cnt;
      r_valid    <= (w_state == ST_HEAD) || (w_state == ST_BODY) || (w_state == ST_TAIL);
      r_data     <= w_data;
      r_busy     <= (w_state != ST_IDLE) && (w_state != ST_DONE);
      r_done     <= (w_state == ST_DONE);
    end
  end

  always_comb begin
    w_state    = r_state;
    w_pkt_cnt  = r_pkt_cnt;
    w_payload  = r_payload;
    w_body_cnt = r_body_cnt;
    w_gap_cnt  = r_gap_cnt;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          w_pkt_cnt  = '0;
          w_payload  = '0;
          w_body_cnt = '0;
          w_gap_cnt  = '0;
          w_state    = (NUM_PKTS == 0) ? ST_DONE : ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (w_xfer) w_state = (PKT_LEN > 0) ? ST_BODY : ST_TAIL;
      end
      ST_BODY: begin
        if (w_xfer) begin
          w_payload = r_payload + 1'b1;
          if (r_body_cnt == PKT_LEN - 1) begin
            w_body_cnt = '0;
            w_state    = ST_TAIL;
          end else begin
            w_body_cnt = r_body_cnt + 1;
          end
        end
      end
      ST_TAIL: begin
        if (w_xfer) begin
          w_pkt_cnt = r_pkt_cnt + 1;
          if (w_pkt_cnt == NUM_PKTS) begin
            w_state = ST_DONE;
          end else if (GAP_CYCLES > 0) begin
            w_gap_cnt = '0;
            w_state   = ST_GAP;
          end else begin
            w_state = ST_HEAD;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_CYCLES - 1) begin
          w_gap_cnt = '0;
          w_state   = ST_HEAD;
        end else begin
          w_gap_cnt = r_gap_cnt + 1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // Flit for the next cycle is built from next-state values so data_o is registered.
  always_comb begin
    w_hdr  = (w_state == ST_TAIL) ? make_tail(STREAM_ID, w_pkt_cnt[SEQ_W-1:0])
                                  : make_head(STREAM_ID, w_pkt_cnt[SEQ_W-1:0]);
    w_data = '0;
    case (w_state)
      ST_HEAD, ST_TAIL: begin
        w_data[DW-1 -: 2]          = w_hdr.ftype;
        w_data[SID_LSB +: SID_W]   = w_hdr.sid;
        w_data[SEQ_LSB +: SEQ_W]   = w_hdr.seq;
      end
      ST_BODY: w_data = {BODY, w_payload};
      default: w_data = '0;
    endcase
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

`ifdef VIRTUAL_INJ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_start_ok;

  assign w_start_ok = start_i & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_virtual_cast_injector.sv
// tb/tb_virtual_cast_injector.sv - directed table-driven bench for virtual_cast_injector
module tb_virtual_cast_injector;

  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, start_b, start_c;
  logic ready_a, ready_b, ready_c;
  logic valid_a, valid_b, valid_c;
  logic [DW-1:0] data_a, data_b, data_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
`ifdef VIRTUAL_INJ_STALL_CNT_EN
  logic [31:0] stall_a, stall_b, stall_c;
`endif

  virtual_cast_injector #(.DW(DW), .STREAM_ID(10'h2A5), .PKT_LEN(2), .NUM_PKTS(2), .GAP_CYCLES(0)) u_a (
    .clk(clk), .rst(rst), .start_i(start_a), .valid_o(valid_a), .data_o(data_a),
    .ready_i(ready_a), .busy_o(busy_a), .done_o(done_a)
`ifdef VIRTUAL_INJ_STALL_CNT_EN
    , .stall_cnt_o(stall_a)
`endif
  );

  virtual_cast_injector #(.DW(DW), .STREAM_ID(10'h013), .PKT_LEN(0), .NUM_PKTS(3), .GAP_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .start_i(start_b), .valid_o(valid_b), .data_o(data_b),
    .ready_i(ready_b), .busy_o(busy_b), .done_o(done_b)
`ifdef VIRTUAL_INJ_STALL_CNT_EN
    , .stall_cnt_o(stall_b)
`endif
  );

  virtual_cast_injector #(.DW(DW), .STREAM_ID(10'h000), .PKT_LEN(4), .NUM_PKTS(0), .GAP_CYCLES(0)) u_c (
    .clk(clk), .rst(rst), .start_i(start_c), .valid_o(valid_c), .data_o(data_c),
    .ready_i(ready_c), .busy_o(busy_c), .done_o(done_c)
`ifdef VIRTUAL_INJ_STALL_CNT_EN
    , .stall_cnt_o(stall_c)
`endif
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t tab_a[9];
  exp_t tab_b[11];
  logic pat[4];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int n;
    int exp_stall;

    tab_a[0] = '{1'b1, 64'h4000_0000_0000_02A5, 1'b1, 1'b0};
    tab_a[1] = '{1'b1, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
    tab_a[2] = '{1'b1, 64'h0000_0000_0000_0001, 1'b1, 1'b0};
    tab_a[3] = '{1'b1, 64'h8000_0000_0000_02A5, 1'b1, 1'b0};
    tab_a[4] = '{1'b1, 64'h4000_0000_0000_06A5, 1'b1, 1'b0};
    tab_a[5] = '{1'b1, 64'h0000_0000_0000_0002, 1'b1, 1'b0};
    tab_a[6] = '{1'b1, 64'h0000_0000_0000_0003, 1'b1, 1'b0};
    tab_a[7] = '{1'b1, 64'h8000_0000_0000_06A5, 1'b1, 1'b0};
    tab_a[8] = '{1'b0, 64'h0000_0000_0000_0000, 1'b0, 1'b1};

    tab_b[0]  = '{1'b1, 64'h4000_0000_0000_0013, 1'b1, 1'b0};
    tab_b[1]  = '{1'b1, 64'h8000_0000_0000_0013, 1'b1, 1'b0};
    tab_b[2]  = '{1'b0, 64'h0, 1'b1, 1'b0};
    tab_b[3]  = '{1'b0, 64'h0, 1'b1, 1'b0};
    tab_b[4]  = '{1'b1, 64'h4000_0000_0000_0413, 1'b1, 1'b0};
    tab_b[5]  = '{1'b1, 64'h8000_0000_0000_0413, 1'b1, 1'b0};
    tab_b[6]  = '{1'b0, 64'h0, 1'b1, 1'b0};
    tab_b[7]  = '{1'b0, 64'h0, 1'b1, 1'b0};
    tab_b[8]  = '{1'b1, 64'h4000_0000_0000_0813, 1'b1, 1'b0};
    tab_b[9]  = '{1'b1, 64'h8000_0000_0000_0813, 1'b1, 1'b0};
    tab_b[10] = '{1'b0, 64'h0, 1'b0, 1'b1};

    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_data",  data_a, 64'd0);
    chk("rst_busy",  64'(busy_a), 64'd0);
    chk("rst_done",  64'(done_a), 64'd0);
`ifdef VIRTUAL_INJ_STALL_CNT_EN
    chk("rst_stall", 64'(stall_a), 64'd0);
`endif

    // Back-to-back run with ready held high
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t1_valid[%0d]", i), 64'(valid_a), 64'(tab_a[i].v));
      chk($sformatf("t1_data[%0d]", i),  data_a, tab_a[i].d);
      chk($sformatf("t1_busy[%0d]", i),  64'(busy_a), 64'(tab_a[i].busy));
      chk($sformatf("t1_done[%0d]", i),  64'(done_a), 64'(tab_a[i].done));
      tick();
    end

    // Same run under a 1,0,0,1 ready pattern
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    k = 0;
    exp_stall = 0;
    for (int cyc = 0; cyc < 60 && k < 8; cyc++) begin
      ready_a = pat[cyc % 4];
      chk($sformatf("t2_valid[%0d]", cyc), 64'(valid_a), 64'd1);
      chk($sformatf("t2_data[%0d]", cyc), data_a, tab_a[k].d);
      if (ready_a) k++;
      else exp_stall++;
      tick();
    end
    ready_a = 1'b1;
    chk("t2_flits", 64'(k), 64'd8);
    chk("t2_done", 64'(done_a), 64'd1);
    chk("t2_busy", 64'(busy_a), 64'd0);
`ifdef VIRTUAL_INJ_STALL_CNT_EN
    chk("t2_stall", 64'(stall_a), 64'(exp_stall));
`endif

    // PKT_LEN=0 with two-cycle gaps
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("t3_valid[%0d]", i), 64'(valid_b), 64'(tab_b[i].v));
      chk($sformatf("t3_data[%0d]", i),  data_b, tab_b[i].d);
      chk($sformatf("t3_busy[%0d]", i),  64'(busy_b), 64'(tab_b[i].busy));
      chk($sformatf("t3_done[%0d]", i),  64'(done_b), 64'(tab_b[i].done));
      tick();
    end

    // NUM_PKTS=0 completes without emitting
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    chk("t4_done", 64'(done_c), 64'd1);
    chk("t4_busy", 64'(busy_c), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_valid[%0d]", i), 64'(valid_c), 64'd0);
      tick();
    end

    // Reset while a body flit is stalled
    start_a = 1'b1;
    ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    chk("t5_pre_data", data_a, 64'd1);
    ready_a = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", 64'(valid_a), 64'd0);
    chk("t5_busy",  64'(busy_a), 64'd0);
    chk("t5_done",  64'(done_a), 64'd0);
    start_a = 1'b1;
    ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("t5_head", data_a, tab_a[0].d);
    tick();
    chk("t5_body_valid", 64'(valid_a), 64'd1);
    chk("t5_body", data_a, tab_a[1].d);
    n = 0;
    while (!done_a && n < 30) begin
      tick();
      n++;
    end
    chk("t5_finish", 64'(done_a), 64'd1);

    // start_i pulsed mid-run must be ignored
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      start_a = (cyc == 2) ? 1'b1 : 1'b0;
      if (valid_a && ready_a) n++;
      tick();
    end
    start_a = 1'b0;
    chk("t6_flits", 64'(n), 64'd8);
    chk("t6_done",  64'(done_a), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
